video_memory_writer: RTL and testbench

VIDEO_MEMORY_WRITER -- requirements
Module: video_memory_writer

---
 rtl/video_memory_writer.sv | 158 +++++++++++++++
 tb/tb_video_memory_writer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/video_memory_writer.sv
// Video RAM writer: full-screen clear after reset, then single-pixel and
// filled-rectangle commands written one pixel per clock in raster order.
module video_memory_writer #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [2:0] CLEAR_COLOR    = 3'd0
) (
  input  logic        Clock_25,
  input  logic        Reset,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic        iCmdOp,
  input  logic [7:0]  iX0,
  input  logic [7:0]  iY0,
  input  logic [7:0]  iX1,
  input  logic [7:0]  iY1,
  input  logic [2:0]  iColor,
  output logic        oWriteEnable,
  output logic [15:0] oWriteAddress,
  output logic [2:0]  oWriteData,
  output logic        oBusy,
  output logic        oDone
);

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [1:0] S_RESET = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
  logic [DW-1:0] color_q, color_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;

  logic [CW-1:0] cmd_xs, cmd_xe, cmd_ys, cmd_ye;

  // Corner normalisation of the incoming command
  always_comb begin
    cmd_xs = iX0;
    cmd_xe = iX0;
    cmd_ys = iY0;
    cmd_ye = iY0;
    if (iCmdOp) begin
      cmd_xs = (iX0 < iX1) ? iX0 : iX1;
      cmd_xe = (iX0 < iX1) ? iX1 : iX0;
      cmd_ys = (iY0 < iY1) ? iY0 : iY1;
      cmd_ye = (iY0 < iY1) ? iY1 : iY0;
    end
  end

  always_ff @(posedge Clock_25 or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RESET;
      x_q     <= '0;
      y_q     <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      color_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      color_q <= color_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next state; the write port registers hold the pixel for the coming cycle
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    color_d = color_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iCmdValid) begin
          xs_d    = cmd_xs;
          xe_d    = cmd_xe;
          ye_d    = cmd_ye;
          color_d = iColor;
          x_d     = cmd_xs;
          y_d     = cmd_ys;
          we_d    = 1'b1;
          addr_d  = {cmd_ys, cmd_xs};
          data_d  = iColor;
          state_d = S_FILL;
        end
      end
      S_CLEAR: begin
        // Exit once 0xFFFF has been presented; {y,x} is the next clear address
        if (we_q && (addr_q == 16'hFFFF)) begin
          state_d = S_IDLE;
        end else begin
          we_d       = 1'b1;
          addr_d     = {y_q, x_q};
          data_d     = CLEAR_COLOR;
          {y_d, x_d} = {y_q, x_q} + AW'(1);
        end
      end
      S_FILL: begin
        if ((x_q == xe_q) && (y_q == ye_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (x_q == xe_q) begin
            x_d = xs_q;
            y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
          we_d   = 1'b1;
          addr_d = {y_d, x_d};
          data_d = color_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign oCmdReady     = (state_q == S_IDLE);
  assign oBusy         = (state_q != S_IDLE);
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oWriteData    = data_q;
  assign oDone         = done_q;

endmodule

// File: tb/tb_video_memory_writer.sv
// Directed bench: instance A clears on reset, instance B (no clear) runs the
// fill commands concurrently with A's clear.
module tb_video_memory_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, a_valid, a_ready, a_op, a_we, a_busy, a_done;
  logic [7:0]  a_x0, a_y0, a_x1, a_y1;
  logic [2:0]  a_col, a_data;
  logic [15:0] a_addr;

  logic        rst_b, b_valid, b_ready, b_op, b_we, b_busy, b_done;
  logic [7:0]  b_x0, b_y0, b_x1, b_y1;
  logic [2:0]  b_col, b_data;
  logic [15:0] b_addr;

  int n_cmp = 0;
  int n_err = 0;

  video_memory_writer #(.CLEAR_ON_RESET(1'b1), .CLEAR_COLOR(3'd0)) dut_a (
    .Clock_25(clk), .Reset(rst_a), .iCmdValid(a_valid), .oCmdReady(a_ready),
    .iCmdOp(a_op), .iX0(a_x0), .iY0(a_y0), .iX1(a_x1), .iY1(a_y1),
    .iColor(a_col), .oWriteEnable(a_we), .oWriteAddress(a_addr),
    .oWriteData(a_data), .oBusy(a_busy), .oDone(a_done)
  );

  video_memory_writer #(.CLEAR_ON_RESET(1'b0), .CLEAR_COLOR(3'd0)) dut_b (
    .Clock_25(clk), .Reset(rst_b), .iCmdValid(b_valid), .oCmdReady(b_ready),
    .iCmdOp(b_op), .iX0(b_x0), .iY0(b_y0), .iX1(b_x1), .iY1(b_y1),
    .iColor(b_col), .oWriteEnable(b_we), .oWriteAddress(b_addr),
    .oWriteData(b_data), .oBusy(b_busy), .oDone(b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command on B and check every write against the raster model
  task automatic run_b(input string tag, input logic op, input logic [7:0] x0, input logic [7:0] y0,
                       input logic [7:0] x1, input logic [7:0] y1, input logic [2:0] col, input bit hold);
    int xs, xe, ys, ye, w, exp_n, n, bad, t;
    logic [15:0] ea;
    if (op) begin
      xs = (x0 < x1) ? int'(x0) : int'(x1);
      xe = (x0 < x1) ? int'(x1) : int'(x0);
      ys = (y0 < y1) ? int'(y0) : int'(y1);
      ye = (y0 < y1) ? int'(y1) : int'(y0);
    end else begin
      xs = int'(x0); xe = int'(x0); ys = int'(y0); ye = int'(y0);
    end
    w     = xe - xs + 1;
    exp_n = w * (ye - ys + 1);
    b_op = op; b_x0 = x0; b_y0 = y0; b_x1 = x1; b_y1 = y1; b_col = col;
    b_valid = 1'b1;
    @(negedge clk); t = 1;
    if (!hold) b_valid = 1'b0;
    check({tag, "_first_we"}, 32'(b_we), 32'd1);
    n = 0; bad = 0;
    while (b_we === 1'b1 && n < 70000) begin
      ea = 16'(((ys + n / w) << 8) + xs + n % w);
      if (b_addr !== ea || b_data !== col || b_done !== 1'b0) bad++;
      n++;
      b_x0 = 8'($urandom); b_y0 = 8'($urandom); b_x1 = 8'($urandom);
      b_y1 = 8'($urandom); b_col = 3'($urandom); b_op = 1'($urandom);
      @(negedge clk); t++;
    end
    check({tag, "_nwrites"}, 32'(n), 32'(exp_n));
    check({tag, "_badwrites"}, 32'(bad), 32'd0);
    check({tag, "_done_pulse"}, 32'(b_done), 32'd1);
    check({tag, "_done_busy"}, 32'(b_busy), 32'd1);
    @(negedge clk); t++;
    check({tag, "_idle_ready"}, 32'(b_ready), 32'd1);
    check({tag, "_idle_nodone"}, 32'(b_done), 32'd0);
    check({tag, "_cycles_to_idle"}, 32'(t), 32'(exp_n + 2));
  endtask

  initial begin
    rst_a = 1'b1; a_valid = 1'b0; a_op = 1'b0; a_x0 = '0; a_y0 = '0; a_x1 = '0; a_y1 = '0; a_col = '0;
    rst_b = 1'b1; b_valid = 1'b0; b_op = 1'b0; b_x0 = '0; b_y0 = '0; b_x1 = '0; b_y1 = '0; b_col = '0;

    fork
      begin : clear_a
        int cyc, n, bad, first;
        bit done_seen;
        repeat (2) @(negedge clk);
        check("a_rst_we", 32'(a_we), 32'd0);
        check("a_rst_addr", 32'(a_addr), 32'd0);
        check("a_rst_ready", 32'(a_ready), 32'd0);
        check("a_rst_busy", 32'(a_busy), 32'd1);
        check("a_rst_done", 32'(a_done), 32'd0);
        rst_a = 1'b0;
        cyc = 0; n = 0; bad = 0; first = -1; done_seen = 1'b0;
        while (cyc < 70000) begin
          @(negedge clk); cyc++;
          if (a_done === 1'b1) done_seen = 1'b1;
          if (a_we === 1'b1) begin
            if (first < 0) first = cyc;
            if (a_addr !== 16'(n) || a_data !== 3'd0) bad++;
            n++;
          end else if (n > 0) begin
            break;
          end
        end
        check("clr_first_cycle", 32'(first), 32'd1);
        check("clr_nwrites", 32'(n), 32'd65536);
        check("clr_badwrites", 32'(bad), 32'd0);
        check("clr_no_done", 32'(done_seen), 32'd0);
        check("clr_ready_after", 32'(a_ready), 32'd1);
        check("clr_busy_after", 32'(a_busy), 32'd0);
      end
      begin : fills_b
        repeat (2) @(negedge clk);
        check("b_rst_ready", 32'(b_ready), 32'd1);
        check("b_rst_busy", 32'(b_busy), 32'd0);
        rst_b = 1'b0;
        @(negedge clk);
        check("b_idle_we", 32'(b_we), 32'd0);
        run_b("op0", 1'b0, 8'd10, 8'd20, 8'd99, 8'd77, 3'b101, 1'b0);
        run_b("rect8", 1'b1, 8'd5, 8'd3, 8'd2, 8'd4, 3'b010, 1'b0);
        run_b("hold1", 1'b1, 8'd200, 8'd7, 8'd201, 8'd6, 3'b011, 1'b1);
        run_b("hold2", 1'b1, 8'd40, 8'd50, 8'd40, 8'd52, 3'b111, 1'b0);
        run_b("full", 1'b1, 8'd255, 8'd0, 8'd0, 8'd255, 3'b100, 1'b0);
      end
    join

    // Reset in the middle of a 4x4 fill on A
    a_op = 1'b1; a_x0 = 8'd1; a_y0 = 8'd1; a_x1 = 8'd4; a_y1 = 8'd4; a_col = 3'b110;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    check("rst_w1_addr", 32'(a_addr), 32'h0101);
    @(negedge clk);
    check("rst_w2_addr", 32'(a_addr), 32'h0102);
    @(negedge clk);
    check("rst_w3_addr", 32'(a_addr), 32'h0103);
    check("rst_w3_we", 32'(a_we), 32'd1);
    rst_a = 1'b1;
    #1;
    check("rst_async_we", 32'(a_we), 32'd0);
    check("rst_async_addr", 32'(a_addr), 32'd0);
    check("rst_async_data", 32'(a_data), 32'd0);
    check("rst_async_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    check("rst_held_done", 32'(a_done), 32'd0);
    rst_a = 1'b0;
    @(negedge clk);
    check("rst_clr0_we", 32'(a_we), 32'd1);
    check("rst_clr0_addr", 32'(a_addr), 32'h0000);
    check("rst_clr0_data", 32'(a_data), 32'd0);
    @(negedge clk);
    check("rst_clr1_addr", 32'(a_addr), 32'h0001);
    check("rst_clr1_done", 32'(a_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
